// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, default width and counter sizing for the restoring divider.
package div_pkg;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;
   localparam int DIV_WIDTH_DEFAULT = 4;
   typedef enum logic [1:0] {IDLE = S_IDLE, RUN = S_RUN, DONE = S_DONE} state_t;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
      return (r < 1) ? 1 : r;
   endfunction
endpackage

// File: rtl/restoring_divider_ctrl_sub.sv
// SUBTRACTOR_N_BIT: a - b with cout=1 meaning no borrow, plus signed overflow.
module SUBTRACTOR_N_BIT #(
   parameter int N = 5
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] out,
   output logic         cout,
   output logic         overflow
);
   assign {cout, out} = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, 1'b1};
   assign overflow = (a[N-1] ^ b[N-1]) & (a[N-1] ^ out[N-1]);
endmodule

// File: rtl/restoring_divider_ctrl.sv
// restoring_divider_ctrl: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Define DIV_ZERO_CHECK_EN to short-circuit a zero divisor straight to DONE with div_by_zero set.
module restoring_divider_ctrl
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = clog2(WIDTH);
   state_t state_q, state_d;
   logic [WIDTH:0] p_q, p_d, ps, diff, p_step;
   logic [WIDTH-1:0] q_q, q_d, d_q, d_d, quo_q, quo_d, rem_q, rem_d, q_step;
   logic [CW-1:0] cnt_q, cnt_d;
   logic dbz_q, dbz_d, cout, zero_div;
   assign ps = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
   SUBTRACTOR_N_BIT #(.N(WIDTH + 1)) u_sub (
      .a(ps), .b({1'b0, d_q}), .out(diff), .cout(cout), .overflow()
   );
   assign p_step = cout ? diff : ps;
   assign q_step = {q_q[WIDTH-2:0], cout};
`ifdef DIV_ZERO_CHECK_EN
   assign zero_div = (divisor == '0);
`else
   assign zero_div = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      p_d = p_q;
      q_d = q_q;
      d_d = d_q;
      cnt_d = cnt_q;
      quo_d = quo_q;
      rem_d = rem_q;
      dbz_d = dbz_q;
      case (state_q)
         IDLE: if (start) begin
            p_d = '0;
            q_d = dividend;
            d_d = divisor;
            cnt_d = CW'(WIDTH - 1);
            state_d = zero_div ? DONE : RUN;
            if (zero_div) begin
               quo_d = '1;
               rem_d = dividend;
               dbz_d = 1'b1;
            end
         end
         RUN: begin
            p_d = p_step;
            q_d = q_step;
            cnt_d = cnt_q - CW'(1);
            // last iteration: publish the freshly computed step directly
            if (cnt_q == '0) begin
               state_d = DONE;
               quo_d = q_step;
               rem_d = p_step[WIDTH-1:0];
               dbz_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         p_q <= '0;
         q_q <= '0;
         d_q <= '0;
         cnt_q <= '0;
         quo_q <= '0;
         rem_q <= '0;
         dbz_q <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q <= p_d;
         q_q <= q_d;
         d_q <= d_d;
         cnt_q <= cnt_d;
         quo_q <= quo_d;
         rem_q <= rem_d;
         dbz_q <= dbz_d;
      end
   end
   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign quotient = quo_q;
   assign remainder = rem_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_divider_ctrl.sv
// tb_restoring_divider_ctrl: scoreboard bench for the 4-bit restoring divider with directed vectors.
module tb_restoring_divider_ctrl;
   typedef struct {
      int q;
      int r;
      int z;
      int lat;
   } exp_t;
   logic clk, rst_n, start, busy, done, div_by_zero;
   logic [3:0] dividend, divisor, quotient, remainder;
   exp_t sb[$];
   int checks = 0, failures = 0, cyc = 0, bcnt = 0, last_q = 0, last_r = 0;
   restoring_divider_ctrl #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );
   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask
   always @(negedge clk) begin
      if (!rst_n) begin
         bcnt = 0;
         last_q = 0;
         last_r = 0;
      end else begin
         if (busy) bcnt++;
         if (done) begin
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("quotient", int'(quotient), e.q);
               chk("remainder", int'(remainder), e.r);
               chk("div_by_zero", int'(div_by_zero), e.z);
               chk("busy_cycles", bcnt, e.lat);
            end
            bcnt = 0;
            last_q = int'(quotient);
            last_r = int'(remainder);
         end else begin
            chk("hold_quotient", int'(quotient), last_q);
            chk("hold_remainder", int'(remainder), last_r);
         end
      end
   end
   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (busy) chk("idle_timeout", 1, 0);
   endtask
   task automatic drain();
      int n = 0;
      while ((busy || sb.size() != 0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain_pending", sb.size(), 0);
   endtask
   task automatic issue(input int a, input int b, input int q, input int r, input int z, input int lat);
      exp_t e;
      wait_idle();
      e.q = q; e.r = r; e.z = z; e.lat = lat;
      sb.push_back(e);
      dividend = 4'(a);
      divisor = 4'(b);
      start = 1;
      @(negedge clk);
      start = 0;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int t[3];
      int va[6] = '{13, 15, 6, 0, 15, 9};
      int vb[6] = '{4, 15, 14, 7, 1, 0};
      int vq[6] = '{3, 1, 0, 0, 15, 15};
      int vr[6] = '{1, 0, 6, 0, 0, 9};
`ifdef DIV_ZERO_CHECK_EN
      int zz = 1, zl = 1;
`else
      int zz = 0, zl = 5;
`endif
      rst_n = 0; start = 0; dividend = 0; divisor = 0;
      #12;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_quotient", int'(quotient), 0);
      chk("rst_remainder", int'(remainder), 0);
      chk("rst_dbz", int'(div_by_zero), 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      for (int i = 0; i < 6; i++)
         issue(va[i], vb[i], vq[i], vr[i], (vb[i] == 0) ? zz : 0, (vb[i] == 0) ? zl : 5);
      drain();
      issue(13, 4, 3, 1, 0, 5);
      start = 1; dividend = 6; divisor = 2;
      @(negedge clk);
      start = 0;
      drain();
      wait_idle();
      dividend = 13; divisor = 4; start = 1;
      @(negedge clk);
      start = 0;
      repeat (2) @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk("arst_busy", int'(busy), 0);
      chk("arst_done", int'(done), 0);
      chk("arst_quotient", int'(quotient), 0);
      chk("arst_remainder", int'(remainder), 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (2) @(negedge clk);
      chk("post_rst_busy", int'(busy), 0);
      issue(10, 3, 3, 1, 0, 5);
      drain();
      wait_idle();
      for (int k = 0; k < 3; k++) begin
         exp_t e;
         e.q = 4; e.r = 2; e.z = 0; e.lat = 5;
         sb.push_back(e);
      end
      dividend = 14; divisor = 3; start = 1;
      for (int k = 0; k < 3; k++) begin
         int n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!done && n < 20);
         if (!done) chk("b2b_timeout", 0, 1);
         t[k] = cyc;
      end
      start = 0;
      chk("b2b_gap0", t[1] - t[0], 6);
      chk("b2b_gap1", t[2] - t[1], 6);
      drain();
      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
